// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the reset PC default, buffer depth, control-state encoding and the buffer entry layout.
package fetch_unit_pkg;

    localparam logic [31:0] FETCH_RESET_PC   = 32'h0000_0000;
    localparam int          FETCH_FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_KILL  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Instruction fetches are word aligned; the low two PC bits carry no meaning.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: ROM read port, branch redirect input and IF->ID handshake.
// master = fetch unit, slave = surrounding pipeline/ROM.
interface fetch_unit_if #(
    parameter int ROM_ADDR_W = 12
);
    logic                  redirect_valid;
    logic [31:0]           redirect_pc;
    logic                  rom_en;
    logic [ROM_ADDR_W-1:0] rom_address;
    logic [31:0]           rom_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_instruction;
    logic [31:0]           out_pc;

    modport master (
        input  redirect_valid, redirect_pc, rom_data, out_ready,
        output rom_en, rom_address, out_valid, out_instruction, out_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, rom_data, out_ready,
        input  rom_en, rom_address, out_valid, out_instruction, out_pc
    );
endinterface

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instruction} buffer between the ROM response and the IF/ID register.
// The head entry is a register so the IF->ID outputs come straight from flops.
module fetch_fifo
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output fetch_entry_t head,
    output logic         head_valid,
    output logic [1:0]   count
);
    fetch_entry_t entry1;
    logic         pop_ok;
    logic         push_ok;

    assign pop_ok     = pop && (count != 2'd0);
    assign push_ok    = push && ((count != 2'd2) || pop_ok);
    assign head_valid = (count != 2'd0);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count <= 2'd0;
        end else begin
            count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    // NOTE: payload registers carry no reset; count alone defines which entries are meaningful.
    always_ff @(posedge clk) begin
        if (pop_ok) begin
            head <= entry1;
        end
        if (push_ok) begin
            // Land in the head slot when it is (or is becoming) the only occupied entry.
            if ((count == 2'd0) || ((count == 2'd1) && pop_ok)) begin
                head <= push_data;
            end else begin
                entry1 <= push_data;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues ROM reads with credit-based flow control against a 2-entry
// buffer, streams one instruction per cycle and restarts from a branch target on redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = FETCH_RESET_PC,
    parameter int          ROM_ADDR_W = 12,
    parameter int          FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);
    logic [31:0]  fetch_pc;
    logic [31:0]  inflight_pc;
    logic         inflight;
    fetch_state_e state;
    logic         kill;
    logic         pop;
    logic         push;
    logic         issue;
    logic [1:0]   count;
    logic [2:0]   occupancy;
    logic [2:0]   next_occupancy;
    fetch_entry_t head;
    logic         head_valid;

    assign kill = (state == ST_KILL);
    assign pop  = head_valid && bus.out_ready;

    // Credit counts buffered entries plus the read in flight; a same-cycle pop frees a slot.
    assign occupancy      = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue          = !reset && !bus.redirect_valid && (occupancy < 3'(FIFO_DEPTH));
    assign push           = inflight && !kill && !bus.redirect_valid;
    assign next_occupancy = {1'b0, count} + {2'b00, push} - {2'b00, pop} + {2'b00, issue};

    assign bus.rom_en          = issue;
    assign bus.rom_address     = fetch_pc[ROM_ADDR_W+1:2];
    assign bus.out_valid       = head_valid;
    assign bus.out_pc          = head.pc;
    assign bus.out_instruction = head.instr;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
            state    <= ST_RUN;
        end else begin
            inflight <= issue;
            if (bus.redirect_valid) begin
                fetch_pc <= align_pc(bus.redirect_pc);
                state    <= ST_KILL;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                state <= (next_occupancy >= 3'(FIFO_DEPTH)) ? ST_STALL : ST_RUN;
            end
        end
    end

    // Tag for the outstanding read; only consumed when inflight says it is live.
    always_ff @(posedge clk) begin
        if (issue) begin
            inflight_pc <= fetch_pc;
        end
    end

    fetch_fifo u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .flush      (bus.redirect_valid),
        .push_data  ('{pc: inflight_pc, instr: bus.rom_data}),
        .head       (head),
        .head_valid (head_valid),
        .count      (count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: ROM model with ROM[i] = 0x1000_0000 + i, cycle-by-cycle
// expectations for streaming, back-pressure, redirects, PC wrap and mid-run reset.
module tb_fetch_unit;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    fetch_unit_if #(.ROM_ADDR_W(12)) bus ();

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .ROM_ADDR_W (12),
        .FIFO_DEPTH (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle-latency ROM.
    always @(posedge clk) begin
        if (bus.rom_en) begin
            bus.rom_data <= 32'h1000_0000 + {20'd0, bus.rom_address};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h, expected %h", tag, got, exp);
        end
    endtask

    // Checks one cycle at the falling edge, then advances past the next rising edge.
    // addr/v of -1 mean "not checked"; pc checked only when v == 1.
    task automatic cyc(input string tag, input bit en, input int addr, input int v,
                       input logic [31:0] pc);
        @(negedge clk);
        check({tag, ".rom_en"}, {31'd0, bus.rom_en}, {31'd0, en});
        if (en && addr >= 0)
            check({tag, ".rom_address"}, {20'd0, bus.rom_address}, 32'(addr));
        if (v >= 0)
            check({tag, ".out_valid"}, {31'd0, bus.out_valid}, 32'(v));
        if (v == 1) begin
            check({tag, ".out_pc"}, bus.out_pc, pc);
            check({tag, ".out_instruction"}, bus.out_instruction,
                  32'h1000_0000 + ((pc >> 2) & 32'h0000_0FFF));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp              = 0;
        n_bad              = 0;
        reset              = 1'b1;
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.rom_data       = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        cyc("reset_hold", 0, -1, 0, 32'h0);

        // Streaming from reset with out_ready held high.
        reset = 1'b0;
        cyc("s_c0", 1, 0, 0, 32'h0);
        cyc("s_c1", 1, 1, 0, 32'h0);
        cyc("s_c2", 1, 2, 1, 32'h0);
        cyc("s_c3", 1, 3, 1, 32'h4);
        cyc("s_c4", 1, 4, 1, 32'h8);

        // Back-pressure from reset: buffer fills with 0x0/0x4 and issue stops.
        reset = 1'b1;
        cyc("bp_rst", 0, -1, -1, 32'h0);
        reset         = 1'b0;
        bus.out_ready = 1'b0;
        cyc("bp_c0", 1, 0, 0, 32'h0);
        cyc("bp_c1", 1, 1, 0, 32'h0);
        cyc("bp_c2", 0, -1, 1, 32'h0);
        cyc("bp_c3", 0, -1, 1, 32'h0);
        cyc("bp_c4", 0, -1, 1, 32'h0);
        cyc("bp_c5", 0, -1, 1, 32'h0);
        bus.out_ready = 1'b1;
        cyc("bp_c6", 1, 2, 1, 32'h0);
        cyc("bp_c7", 1, 3, 1, 32'h4);
        bus.out_ready = 1'b0;
        cyc("bp_c8", 0, -1, 1, 32'h8);

        // Redirect with 0x8/0xC buffered.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0100;
        cyc("rd1_t", 0, -1, 1, 32'h8);
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b1;
        cyc("rd1_t1", 1, 'h40, 0, 32'h0);
        cyc("rd1_t2", 1, 'h41, 0, 32'h0);
        cyc("rd1_t3", 1, 'h42, 1, 32'h100);
        cyc("rd1_t4", 1, 'h43, 1, 32'h104);

        // Redirect to a misaligned target while popping and receiving ROM data.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0203;
        cyc("rd2_t", 0, -1, 1, 32'h108);
        bus.redirect_valid = 1'b0;
        cyc("rd2_t1", 1, 'h80, 0, 32'h0);
        cyc("rd2_t2", 1, 'h81, 0, 32'h0);
        cyc("rd2_t3", 1, 'h82, 1, 32'h200);

        // Back-to-back redirects: only the latest target survives.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0300;
        cyc("rd3_a", 0, -1, 1, 32'h204);
        bus.redirect_pc = 32'h0000_0400;
        cyc("rd3_b", 0, -1, 0, 32'h0);
        bus.redirect_valid = 1'b0;
        cyc("rd3_t1", 1, 'h100, 0, 32'h0);
        cyc("rd3_t2", 1, 'h101, 0, 32'h0);
        cyc("rd3_t3", 1, 'h102, 1, 32'h400);

        // PC wrap from the top of the address space.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        cyc("wr_t", 0, -1, 1, 32'h404);
        bus.redirect_valid = 1'b0;
        cyc("wr_t1", 1, 'hFFF, 0, 32'h0);
        cyc("wr_t2", 1, 'h000, 0, 32'h0);
        cyc("wr_t3", 1, 'h001, 1, 32'hFFFF_FFFC);
        cyc("wr_t4", 1, 'h002, 1, 32'h0000_0000);

        // Reset mid-stream with an entry buffered and a read in flight.
        reset = 1'b1;
        cyc("mr1_rst", 0, -1, -1, 32'h0);
        reset = 1'b0;
        cyc("mr1_c0", 1, 0, 0, 32'h0);
        cyc("mr1_c1", 1, 1, 0, 32'h0);
        cyc("mr1_c2", 1, 2, 1, 32'h0);

        // Reset with the buffer full.
        bus.out_ready = 1'b0;
        cyc("mr2_f0", 0, -1, 1, 32'h4);
        cyc("mr2_f1", 0, -1, 1, 32'h4);
        reset = 1'b1;
        cyc("mr2_rst", 0, -1, -1, 32'h0);
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        cyc("mr2_c0", 1, 0, 0, 32'h0);
        cyc("mr2_c1", 1, 1, 0, 32'h0);
        cyc("mr2_c2", 1, 2, 1, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
